// File: rtl/shift_rows_seq.sv
// Handshaked AES ShiftRows engine, one row rotated per clock.
// Forward and inverse rotation selected per block; state is column-major.
module shift_rows_seq #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int BYTE_W = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ROWS*COLS*BYTE_W-1:0] in_state,
   input  logic                        in_inverse,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ROWS*COLS*BYTE_W-1:0] out_state,
   output logic                        busy
);

   localparam int N  = ROWS * COLS * BYTE_W;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    state;
   logic [N-1:0]  w;
   logic [N-1:0]  nxt;
   logic [RW-1:0] row;
   logic          mode;

   // Only the row selected by the counter is rewritten; others pass through.
   always_comb begin
      nxt = w;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (int'(row) == r) begin
               if (mode)
                  nxt[BYTE_W*(r+ROWS*c) +: BYTE_W] =
                     w[BYTE_W*(r+ROWS*((c+COLS-(r%COLS))%COLS)) +: BYTE_W];
               else
                  nxt[BYTE_W*(r+ROWS*c) +: BYTE_W] =
                     w[BYTE_W*(r+ROWS*((c+r)%COLS)) +: BYTE_W];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         w     <= '0;
         row   <= '0;
         mode  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  w     <= in_state;
                  mode  <= in_inverse;
                  row   <= '0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               w <= nxt;
               if (row == LAST)
                  state <= S_DONE;
               else
                  row <= row + 1'b1;
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_SHIFT) || (state == S_DONE);
   assign out_state = w;

endmodule

// File: doc/shift_rows_seq.md
Name: shift_rows_seq

Overview:
- Parametrised, handshaked ShiftRows engine for the AES datapath. Generalises the fixed 2x2, 4-bit prototype to ROWS x COLS states of BYTE_W-bit elements.
- Supports forward (encrypt) and inverse (decrypt) mode, selected per block.
- Processes one row per clock through an explicit FSM, with valid/ready on both sides.
- Sits between SubBytes and MixColumns in the iterative round pipeline.

Parameters:
- ROWS, 4, number of state rows; must be >= 1.
- COLS, 4, number of state columns (Nb); must be >= 1.
- BYTE_W, 8, bits per state element.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state and in_inverse are valid.
- in_ready  output  1  block can accept a state.
- in_state  input  ROWS*COLS*BYTE_W  input state, column-major (see Behaviour).
- in_inverse  input  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with in_state.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  ROWS*COLS*BYTE_W  shifted state, same layout as input.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Layout: element (r,c), 0-based, has index i = r + ROWS*c and occupies bits [BYTE_W*i + BYTE_W-1 : BYTE_W*i].
- Forward mode: out(r,c) = in(r, (c + r) mod COLS).
- Inverse mode: out(r,c) = in(r, (c - r) mod COLS), computed modulo COLS with no negative indexing.
- Row r rotates by r mod COLS. This covers ROWS > COLS and the degenerate COLS = 1 case (identity).
- Internal state: working register W (full state width), latched mode bit, row counter of width max(1, clog2(ROWS)), FSM.
- FSM states and transitions:
  - IDLE: in_ready = 1, busy = 0. On in_valid && in_ready: load W <= in_state, latch in_inverse, row counter <= 0, go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle, replace row[row counter] of W with its rotated version; all other rows are unchanged. If row counter == ROWS-1, go to DONE; otherwise increment the counter.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Latency: the acceptance edge is edge 0. out_valid rises after edge ROWS (exactly ROWS cycles, row 0 included). in_ready returns to 1 the cycle after the out_ready handshake.
- Throughput: at most one block per ROWS+2 cycles. There is no overlap of input and output.
- out_state is driven from W and is meaningful only while out_valid is high. In DONE it holds stable regardless of in_valid, in_inverse or in_state changes.
- in_valid is ignored outside IDLE. in_state and in_inverse changes after acceptance have no effect.
- out_ready is ignored outside DONE.
- Reset:
  - Asynchronous reset forces IDLE, W = 0, row counter = 0, mode = 0.
  - Outputs after reset: out_valid = 0, out_state = 0, busy = 0, in_ready = 1.
  - Reset during SHIFT or DONE discards the block; no partial result is ever presented.
- in_ready, out_valid and busy are decoded from FSM state only. There is no combinational path from in_valid or out_ready to any output.
- ROWS = 1: SHIFT lasts one cycle and the result is the input unchanged.

Test Plan:
1. FIPS-197 forward vector, default parameters. Apply in_state bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 with in_inverse = 0 -> out_valid after exactly 4 cycles; out bytes 0..15 = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
2. Inverse vector. Apply the output of test 1 with in_inverse = 1 -> out_state equals the original input of test 1. Also run forward then inverse on 16 random states -> round-trip is the identity every time.
3. ROWS=2, COLS=2, BYTE_W=4. Apply elements 0..3 = 0,1,2,3 -> elements 0,3,2,1 in both modes; latency 2 cycles.
4. Backpressure. Hold out_ready = 0 for 5 cycles in DONE while toggling in_valid and in_state -> out_state stable, out_valid = 1, in_ready = 0. Raise out_ready -> in_ready = 1 next cycle, and a second block is accepted and correct.
5. Reset mid-operation. Assert reset 2 cycles into SHIFT -> immediately out_valid = 0, out_state = 0, in_ready = 1. The next block completes correctly with a latency of 4 cycles.
6. ROWS=6, COLS=4. Elements set to index i -> row 4 rotated by 0, row 5 by 1, row 1 by 1, row 3 by 3; out_valid after 6 cycles.
